// File: rtl/fir_pkg.sv
// Shared types and default constants for the FIR low-pass chain
// (FIR core, decimating AXIS output stage, AXI wrapper).
package fir_pkg;
  localparam int SAMPLE_W       = 16;
  localparam int DECIM_DEF      = 4;
  localparam int FRAME_LEN_DEF  = 256;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO is legal
// when a read happens in the same cycle. rd_data holds the last popped word when empty.
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] last_q, last_d;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    level_d  = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    last_d   = last_q;
    if (rd_en) last_d = mem_q[rd_ptr_q];
  end

  // Storage is not reset; only the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/fir_decim_axis_out.sv
// Decimates FIR output samples, buffers them and streams them as AXIS with TLAST framing.
// Kept sample visible one cycle after capture; under back-pressure a full FIFO drops and flags overflow.
module fir_decim_axis_out
  import fir_pkg::*;
#(
  parameter  int DATA_W     = SAMPLE_W,
  parameter  int DECIM      = DECIM_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter  int FRAME_LEN  = FRAME_LEN_DEF,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_en,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              overflow,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              ovf_q, ovf_d;
  logic              fifo_full, fifo_empty;
  logic              keep, push, pop, drop;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt_q == BEAT_W'(FRAME_LEN - 1));
  assign overflow      = ovf_q;

  always_comb begin
    keep = enable && sample_en && (dec_cnt_q == '0);
    pop  = m_axis_tvalid && m_axis_tready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = keep && (!fifo_full || pop);
    drop = keep && fifo_full && !pop;

    dec_cnt_d = dec_cnt_q;
    if (enable && sample_en)
      dec_cnt_d = (dec_cnt_q == DEC_W'(DECIM - 1)) ? '0 : dec_cnt_q + 1'b1;

    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    beat_cnt_d = beat_cnt_q;
    if (pop) beat_cnt_d = m_axis_tlast ? '0 : beat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_cnt_q  <= '0;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      dec_cnt_q  <= dec_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (sample_in),
    .rd_en   (pop),
    .rd_data (m_axis_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_fir_decim_axis_out.sv
// Directed bench: three instances (DECIM=4 / DECIM=1,FRAME_LEN=4 / DECIM=2) share stimulus;
// each test resets all of them and checks the instance it targets.
module tb_fir_decim_axis_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_en;
  logic        clr_ovf;
  logic        tready;

  logic [15:0] a_tdata, b_tdata, c_tdata;
  logic        a_tvalid, b_tvalid, c_tvalid;
  logic        a_tlast, b_tlast, c_tlast;
  logic        a_ovf, b_ovf, c_ovf;
  logic [4:0]  a_level, b_level, c_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_decim_axis_out #(.DATA_W(16), .DECIM(4), .FIFO_DEPTH(16), .FRAME_LEN(256)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in), .sample_en(sample_en),
    .clr_ovf(clr_ovf), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(a_tlast), .overflow(a_ovf), .fifo_level(a_level));

  fir_decim_axis_out #(.DATA_W(16), .DECIM(1), .FIFO_DEPTH(16), .FRAME_LEN(4)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in), .sample_en(sample_en),
    .clr_ovf(clr_ovf), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(b_tlast), .overflow(b_ovf), .fifo_level(b_level));

  fir_decim_axis_out #(.DATA_W(16), .DECIM(2), .FIFO_DEPTH(16), .FRAME_LEN(256)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in), .sample_en(sample_en),
    .clr_ovf(clr_ovf), .m_axis_tdata(c_tdata), .m_axis_tvalid(c_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(c_tlast), .overflow(c_ovf), .fifo_level(c_level));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b1; sample_en = 1'b0; clr_ovf = 1'b0; tready = 1'b0; sample_in = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_tvalid", 16'(a_tvalid), 16'd0);
    chk("rst_tlast",  16'(a_tlast),  16'd0);
    chk("rst_ovf",    16'(a_ovf),    16'd0);
    chk("rst_level",  16'(a_level),  16'd0);
    chk("rst_tdata",  a_tdata,       16'd0);

    // DECIM=4, tready=1: samples 0..11 give beats 0,4,8, each one cycle after capture
    tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample_in = 16'(i); sample_en = 1'b1;
      step();
      chk("d4_tvalid", 16'(a_tvalid), 16'((i % 4) == 0));
      if ((i % 4) == 0) chk("d4_tdata", a_tdata, 16'(i));
    end
    sample_en = 1'b0;

    // DECIM=1, tready=0, 20 strobes 100..119: fill to 16, overflow after 17th
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      sample_in = 16'(99 + k); sample_en = 1'b1;
      step();
      chk("fill_level", 16'(b_level), 16'((k > 16) ? 16 : k));
      chk("fill_ovf",   16'(b_ovf),   16'(k >= 17));
      chk("fill_tdata", b_tdata,      16'd100);
    end
    sample_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_tvalid", 16'(b_tvalid), 16'd1);
      chk("stall_tdata",  b_tdata,       16'd100);
    end
    tready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("drain_tvalid", 16'(b_tvalid), 16'd1);
      chk("drain_tdata",  b_tdata,       16'(100 + j));
      chk("drain_tlast",  16'(b_tlast),  16'((j % 4) == 3));
      step();
    end
    chk("drained_tvalid", 16'(b_tvalid), 16'd0);
    chk("drained_level",  16'(b_level),  16'd0);
    chk("drained_tdata",  b_tdata,       16'd115);

    // Full FIFO with simultaneous pop and push
    do_reset();
    for (int k = 0; k < 16; k++) begin
      sample_in = 16'(100 + k); sample_en = 1'b1;
      step();
    end
    chk("full_level", 16'(b_level), 16'd16);
    tready = 1'b1; sample_in = 16'd200; sample_en = 1'b1;
    step();
    tready = 1'b0; sample_en = 1'b0;
    chk("fullpp_level", 16'(b_level), 16'd16);
    chk("fullpp_ovf",   16'(b_ovf),   16'd0);
    chk("fullpp_head",  b_tdata,      16'd101);

    // FRAME_LEN=4, samples -5..4: tlast on -2 and 2
    do_reset();
    tready = 1'b1;
    for (int s = -5; s <= 4; s++) begin
      sample_in = 16'(s); sample_en = 1'b1;
      step();
      chk("frm_tvalid", 16'(b_tvalid), 16'd1);
      chk("frm_tdata",  b_tdata,       16'(s));
      chk("frm_tlast",  16'(b_tlast),  16'((s == -2) || (s == 2)));
    end
    sample_en = 1'b0;
    step();
    chk("frm_end_tvalid", 16'(b_tvalid), 16'd0);

    // DECIM=2: enable=0 holds the phase across 3 strobes
    do_reset();
    tready = 1'b1;
    sample_in = 16'd10; sample_en = 1'b1;
    step();
    chk("en_first_tvalid", 16'(c_tvalid), 16'd1);
    chk("en_first_tdata",  c_tdata,       16'd10);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_in = 16'(20 + k);
      step();
      chk("en_off_tvalid", 16'(c_tvalid), 16'd0);
      chk("en_off_level",  16'(c_level),  16'd0);
    end
    enable = 1'b1; sample_in = 16'd11;
    step();
    chk("en_resume_skip", 16'(c_tvalid), 16'd0);
    sample_in = 16'd12;
    step();
    chk("en_resume_tvalid", 16'(c_tvalid), 16'd1);
    chk("en_resume_tdata",  c_tdata,       16'd12);

    // Fill C under back-pressure until a kept sample is dropped
    tready = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      sample_in = 16'(300 + i); sample_en = 1'b1;
      step();
      chk("c_fill_ovf", 16'(c_ovf), 16'(i >= 32));
    end
    chk("c_full_level", 16'(c_level), 16'd16);
    chk("c_full_head",  c_tdata,      16'd12);
    sample_en = 1'b0; clr_ovf = 1'b1;
    step();
    chk("clr_ovf", 16'(c_ovf), 16'd0);
    clr_ovf = 1'b0; sample_en = 1'b1;
    step();
    chk("clr_ovf_hold", 16'(c_ovf), 16'd0);
    clr_ovf = 1'b1;
    step();
    chk("ovf_set_wins", 16'(c_ovf), 16'd1);
    clr_ovf = 1'b0; sample_en = 1'b0;

    // Reset mid-frame with 5 queued entries
    do_reset();
    tready = 1'b1; sample_in = 16'd1; sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    step();
    tready = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      sample_in = 16'(k); sample_en = 1'b1;
      step();
    end
    sample_en = 1'b0;
    chk("mid_level", 16'(b_level), 16'd5);
    reset = 1'b0;
    step();
    chk("mid_rst_tvalid", 16'(b_tvalid), 16'd0);
    chk("mid_rst_level",  16'(b_level),  16'd0);
    chk("mid_rst_ovf",    16'(b_ovf),    16'd0);
    reset = 1'b1; tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample_in = 16'(50 + k); sample_en = 1'b1;
      step();
      chk("newfrm_tdata", b_tdata,      16'(50 + k));
      chk("newfrm_tlast", 16'(b_tlast), 16'(k == 3));
    end
    sample_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_decim_axis_out.md
Name: fir_decim_axis_out

Overview:
Downstream stage of the 49-tap FIR low-pass filter. It captures each filtered sample on the FIR's sample strobe and keeps every DECIM-th sample. Kept samples are buffered in a small synchronous FIFO and presented as an AXI4-Stream master, with TLAST framing every FRAME_LEN beats. A sticky overflow flag reports samples dropped under back-pressure.

Parameters:
- DATA_W, 16, sample width; matches FIR data_out.
- DECIM, 4, decimation factor (≥1); 1 = keep every sample.
- FIFO_DEPTH, 16, FIFO entries (power of 2, ≥2).
- FRAME_LEN, 256, AXIS beats per TLAST frame (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = capture and decimate; 0 = hold the decimation phase, no pushes, FIFO still drains.
- sample_in  in  DATA_W  signed filtered sample (FIR data_out).
- sample_en  in  1  sample_in valid this cycle (FIR strobe delayed one cycle by the integrator).
- clr_ovf  in  1  single-cycle clear of overflow.
- m_axis_tdata  out  DATA_W  head FIFO entry.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of frame.
- overflow  out  1  sticky: a kept sample was dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0 at posedge): decimation counter, FIFO pointers, beat counter and overflow go to 0. Outputs: tvalid=0, tlast=0, overflow=0, fifo_level=0, tdata=0. Reset mid-frame discards FIFO contents and restarts the frame count.
- Decimation counter dec_cnt runs 0..DECIM-1.
  - It advances only on cycles with sample_en=1 and enable=1, wrapping DECIM-1→0.
  - A sample is kept when sample_en=1, enable=1 and dec_cnt==0. The first sample after reset is therefore kept.
  - With enable=0, sample_en is ignored and dec_cnt holds.
- Push: keep && (!full || pop). A full FIFO accepts a push in the same cycle as a pop; level is unchanged.
- Drop: keep && full && !pop. The sample is discarded and overflow is set to 1 at the next edge.
- overflow clears on clr_ovf=1. If a drop and clr_ovf occur in the same cycle, set wins.
- Pop: m_axis_tvalid && m_axis_tready.
- Latency: a sample kept at cycle N appears on the stream with tvalid=1 at cycle N+1, when the FIFO was empty.
- FIFO is first-word-fall-through. tdata shows the head entry combinationally from the register array and is stable while tvalid=1 and tready=0 (AXIS rule).
- tvalid is never deasserted without a handshake.
- When the FIFO is empty, tdata shows the last popped value, or 0 after reset.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. full means level==FIFO_DEPTH; empty means level==0.
- fifo_level = level + push − pop, registered.
- Beat counter beat_cnt runs 0..FRAME_LEN-1.
  - It increments on each pop and wraps to 0 after the pop where tlast=1.
  - tlast = tvalid && (beat_cnt==FRAME_LEN-1).
  - Dropped samples do not count toward the frame.
- Data is passed unmodified: no arithmetic, sign preserved.

Decomposition:
- Package fir_pkg holds:
  - SAMPLE_W=16;
  - typedef sample_t (signed [SAMPLE_W-1:0]);
  - default DECIM and FRAME_LEN constants, shared with the FIR and the AXI wrapper.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - interface: FWFT read, wr_en/rd_en, full/empty/level;
  - simultaneous read/write when full is allowed.
- Decimation, overflow and framing logic live in the top module.

Test Plan:
- DECIM=4, tready=1, sample_en every cycle, samples 0,1,2,…,11 → stream beats 0,4,8. Each beat's tvalid appears one cycle after its capture.
- DECIM=1, FIFO_DEPTH=16, tready=0, 20 strobes with samples 100..119:
  - fifo_level reaches 16 and the FIFO holds 100..115;
  - overflow=1 from the cycle after the 17th strobe;
  - on releasing tready, beats 100..115 come out in order with tdata stable while stalled.
- FIFO full with tready=1 and strobe in the same cycle → push accepted, level stays 16, overflow stays 0.
- FRAME_LEN=4, DECIM=1, 10 samples −5..4 → tlast on beats −2 and 2 only; beat counter wraps after each.
- enable=0 for 3 strobes mid-stream with DECIM=2 → no pushes, dec_cnt is held, and the phase resumes after enable=1. Set overflow, then pulse clr_ovf → overflow=0 next cycle.
- Assert reset=0 with 5 entries queued and mid-frame → next cycle tvalid=0, level=0, overflow=0. The first kept sample after release starts a new frame.
